// File: rtl/motor_drive.sv
// motor_drive: steering state to slew-limited per-wheel PWM and direction with lost-line recovery
module motor_drive #(
  parameter int PWM_BITS = 10,
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FAST = 800,
  parameter int DUTY_SLOW = 500,
  parameter int DUTY_SHARP = 300,
  parameter int RAMP_STEP = 50,
  parameter int LOST_TIMEOUT = 50000,
  parameter int SEARCH_TIMEOUT = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       dir_left,
  output logic       dir_right,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {TRACK = 2'b00, LOST_WAIT = 2'b01, SEARCH = 2'b10, HALT = 2'b11} mode_t;
  localparam int LW = $clog2(LOST_TIMEOUT + 1);
  localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [PWM_BITS-1:0] ZERO = '0;
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(PWM_PERIOD - 1);
  localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(DUTY_SLOW);
  localparam logic [PWM_BITS-1:0] SHARP = PWM_BITS'(DUTY_SHARP);
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
  localparam logic [LW-1:0] LOST_MAX = LW'(LOST_TIMEOUT);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  mode_t fsm;
  logic [PWM_BITS-1:0] cnt, duty_left, duty_right, tgt_duty_left, tgt_duty_right;
  logic [PWM_BITS-1:0] cmd_duty_left, cmd_duty_right;
  logic tgt_dir_left, tgt_dir_right, last_turn, go, wrap;
  logic [2:0] cmd;
  logic [LW-1:0] lost_cnt;
  logic [SW-1:0] search_cnt;
  function automatic logic [PWM_BITS:0] ramp(input logic dir, input logic [PWM_BITS-1:0] duty,
                                             input logic tdir, input logic [PWM_BITS-1:0] tduty);
    if (dir != tdir) return (duty == ZERO) ? {tdir, ZERO} : {dir, (duty > STEP) ? duty - STEP : ZERO};
    if (tduty > duty) return {dir, (tduty - duty > STEP) ? duty + STEP : tduty};
    return {dir, (duty - tduty > STEP) ? duty - STEP : tduty};
  endfunction
  assign mode = fsm;
  always_comb begin
    go = (state != 3'b011) && !(state[2] && state[1]);
    wrap = cnt == CNT_MAX;
    cmd = go ? state : {2'b10, last_turn};
    cmd_duty_left = (cmd == 3'b100) ? SHARP : (cmd == 3'b000) ? SLOW : FAST;
    cmd_duty_right = (cmd == 3'b101) ? SHARP : (cmd == 3'b001) ? SLOW : FAST;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= ZERO;
      duty_left <= ZERO;
      duty_right <= ZERO;
      tgt_duty_left <= ZERO;
      tgt_duty_right <= ZERO;
      tgt_dir_left <= 1'b1;
      tgt_dir_right <= 1'b1;
      dir_left <= 1'b1;
      dir_right <= 1'b1;
      pwm_left <= 1'b0;
      pwm_right <= 1'b0;
      fsm <= TRACK;
      last_turn <= 1'b0;
      lost_cnt <= '0;
      search_cnt <= '0;
    end else begin
      cnt <= wrap ? ZERO : cnt + 1'b1;
      pwm_left <= cnt < duty_left;
      pwm_right <= cnt < duty_right;
      if (wrap) begin
        {dir_left, duty_left} <= ramp(dir_left, duty_left, tgt_dir_left, tgt_duty_left);
        {dir_right, duty_right} <= ramp(dir_right, duty_right, tgt_dir_right, tgt_duty_right);
      end
      if (go) begin
        fsm <= TRACK;
        if (state != 3'b010) last_turn <= state[0];
      end else if (fsm == TRACK) begin
        fsm <= LOST_WAIT;
        lost_cnt <= LW'(1);
      end else if (fsm == LOST_WAIT) begin
        lost_cnt <= lost_cnt + 1'b1;
        if (lost_cnt == LOST_MAX) begin
          fsm <= SEARCH;
          search_cnt <= '0;
        end
      end else if (fsm == SEARCH) begin
        search_cnt <= search_cnt + 1'b1;
        if (search_cnt == SEARCH_LAST) fsm <= HALT;
      end
      if (go || fsm == SEARCH) begin
        tgt_dir_left <= cmd != 3'b100;
        tgt_dir_right <= cmd != 3'b101;
        tgt_duty_left <= cmd_duty_left;
        tgt_duty_right <= cmd_duty_right;
      end else if (fsm == HALT) begin
        tgt_duty_left <= ZERO;
        tgt_duty_right <= ZERO;
      end
    end
  end
endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Downstream consumer of the line-tracker 3-bit steering state.
- Converts the steering state into per-wheel PWM and direction signals for the H-bridge.
- Slew-limits duty changes and forces duty to 0 before any direction reversal.
- Runs a lost-line recovery FSM (wait, pivot-search, halt) when the tracker reports stop.

Parameters:
PWM_BITS, 10, width of PWM counter and duty registers
PWM_PERIOD, 1000, PWM period in clk cycles; counter runs 0..PWM_PERIOD-1
DUTY_FAST, 800, duty for the outer/straight wheel
DUTY_SLOW, 500, duty for the inner wheel on a gentle turn
DUTY_SHARP, 300, reverse duty for the inner wheel on a sharp pivot
RAMP_STEP, 50, maximum duty change per PWM period
LOST_TIMEOUT, 50000, cycles of continuous stop before search starts
SEARCH_TIMEOUT, 2000000, cycles of search before halting

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (asserted when 0)
state  input  3  steering command: 000 turn_left, 001 turn_right, 010 go_straight, 011 stop, 100 sharp_left, 101 sharp_right; 110/111 treated as stop
pwm_left  output  1  left motor PWM
pwm_right  output  1  right motor PWM
dir_left  output  1  left motor direction, 1 = forward
dir_right  output  1  right motor direction, 1 = forward
mode  output  2  recovery FSM state: 00 TRACK, 01 LOST_WAIT, 10 SEARCH, 11 HALT

Behaviour:
- Reset (reset==0 at a clk edge), all registers:
  - cnt=0; duty_left=duty_right=0; targets=0.
  - dir_left=dir_right=1; pwm_left=pwm_right=0.
  - mode=TRACK; last_turn=0 (left); lost/search counters = 0.
- Reset overrides everything, including mid-ramp and mid-search.
- PWM counter: cnt increments each cycle and wraps from PWM_PERIOD-1 to 0.
- PWM output: registered, pwm_x(t+1) = (cnt(t) < duty_x(t)).
  - duty 0 gives a constant-low output.
  - duty >= PWM_PERIOD gives a constant-high output.
- Target table, as (left dir/duty, right dir/duty):
  - go_straight: F/FAST, F/FAST
  - turn_left: F/SLOW, F/FAST
  - turn_right: F/FAST, F/SLOW
  - sharp_left: R/SHARP, F/FAST
  - sharp_right: F/FAST, R/SHARP
- last_turn: set to 0 on turn_left/sharp_left and to 1 on turn_right/sharp_right, in any mode.
- FSM, evaluated every cycle:
  - TRACK:
    - Non-stop state: targets come from the table.
    - Stop state: go to LOST_WAIT with lost counter = 1; targets keep their last values (coast).
  - LOST_WAIT:
    - Non-stop state: go to TRACK.
    - Otherwise increment the counter; when it reaches LOST_TIMEOUT, go to SEARCH with search counter = 0.
    - Targets hold.
  - SEARCH:
    - Pivot toward last_turn: the sharp_left targets if last_turn=0, the sharp_right targets if 1.
    - Non-stop state: go to TRACK immediately.
    - Search counter reaches SEARCH_TIMEOUT: go to HALT.
  - HALT:
    - Both targets are duty 0, direction unchanged.
    - Any non-stop state: go to TRACK.
- Ramp, applied only on the cycle cnt == PWM_PERIOD-1, independently per wheel:
  - Target dir differs from current dir and duty > 0: duty decreases by min(RAMP_STEP, duty); dir unchanged.
  - Target dir differs and duty == 0: dir flips to the target on this update; duty stays 0 for this update.
  - Same dir: duty moves toward the target by at most RAMP_STEP and clamps exactly at the target (no overshoot).
- Direction changes only while that wheel's duty is 0; a direction change while PWM is high is illegal.
- Duty and dir are stable within a PWM period (glitch-free PWM).
- Simultaneous events: the FSM transition and target update on a wrap cycle take effect at the next wrap; the ramp uses targets registered before the edge.

Test Plan:
- Bench parameters: PWM_PERIOD=10, DUTY_FAST=8, DUTY_SLOW=5, DUTY_SHARP=4, RAMP_STEP=3, LOST_TIMEOUT=20, SEARCH_TIMEOUT=60.
- Reset then state=go_straight held:
  - Duty sequence per period is 0,3,6,8 on both wheels.
  - pwm_left is high for exactly 8 of every 10 cycles once settled; dirs stay 1; mode=00.
- From settled go_straight, switch to sharp_left:
  - duty_left goes 8,5,2,0, then dir_left becomes 0, then 0,3,4 reverse.
  - Right wheel stays at 8.
  - dir_left never toggles while duty_left>0.
- turn_right, then stop held:
  - mode goes 01 for 20 cycles, then 10.
  - Pivot is right (dir_right→0, duty_right→4 after ramp).
  - After 60 more cycles mode=11 and both duties ramp to 0.
- During SEARCH (mode=10), apply turn_left for one cycle:
  - mode=00 next cycle; targets become left 5 / right 8 forward; last_turn=0.
- Stop held only 10 cycles then go_straight:
  - mode returns 01→00 without entering SEARCH; duties unchanged during LOST_WAIT.
- Assert reset=0 mid-ramp and mid-SEARCH:
  - Next cycle all outputs are at reset values (pwm 0, dirs 1, mode 00).
  - state=110 behaves identically to 011.
